// File: rtl/cp0.sv
// Coprocessor 0: status, cause, EPC and PRId registers with exception and
// interrupt request generation for a single-issue pipeline (request taken in M).
module cp0 (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic [4:0]  ExcCode_M,
  input  logic        writec0_M,
  input  logic        EXLClr_M,
  input  logic [5:0]  HWInt,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        req
);

  localparam logic [4:0]  RegSr    = 5'd12;
  localparam logic [4:0]  RegCause = 5'd13;
  localparam logic [4:0]  RegEpc   = 5'd14;
  localparam logic [4:0]  RegPrid  = 5'd15;
  localparam logic [31:0] PridVal  = 32'h2022_0007;

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] epc_exc;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign int_req = (|(HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
  assign exc_req = (ExcCode_M != 5'd0) & ~sr_exl_q;
  assign req     = int_req | exc_req;

  // A delay-slot instruction restarts at its branch; subtraction wraps mod 2^32.
  assign epc_exc = (BD_M ? (PC_M - 32'd4) : PC_M) & 32'hFFFF_FFFC;

  assign sr_val    = {16'h0, sr_im_q, 8'h0, sr_exl_q, sr_ie_q};
  assign cause_val = {cause_bd_q, 15'h0, cause_ip_q, 3'h0, cause_exc_q, 2'h0};
  assign EPCOut    = epc_q;

  // mfc0 read mux; unmapped register numbers read as zero.
  always_comb begin
    CP0Out = 32'h0;
    case (A1)
      RegSr:    CP0Out = sr_val;
      RegCause: CP0Out = cause_val;
      RegEpc:   CP0Out = epc_q;
      RegPrid:  CP0Out = PridVal;
      default:  CP0Out = 32'h0;
    endcase
  end

  // Next-state: exception entry beats mtc0 and eret; eret beats an mtc0 of EXL.
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = HWInt;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (req) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = BD_M;
      cause_exc_d = int_req ? 5'd0 : ExcCode_M;
      epc_d       = epc_exc;
    end else begin
      if (writec0_M) begin
        if (A2 == RegSr) begin
          sr_im_d  = DIn[15:10];
          sr_exl_d = DIn[1];
          sr_ie_d  = DIn[0];
        end else if (A2 == RegEpc) begin
          epc_d = {DIn[31:2], 2'b00};
        end
      end
      if (EXLClr_M) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset; PRId is a constant and not stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_q     <= 6'h0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'h0;
      cause_exc_q <= 5'h0;
      epc_q       <= 32'h0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0.
module tb_cp0;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, ExcCode_M;
  logic [31:0] DIn, PC_M;
  logic        BD_M, writec0_M, EXLClr_M;
  logic [5:0]  HWInt;
  logic [31:0] CP0Out, EPCOut;
  logic        req;

  int n_cmp = 0;
  int n_bad = 0;

  cp0 dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .DIn       (DIn),
    .PC_M      (PC_M),
    .BD_M      (BD_M),
    .ExcCode_M (ExcCode_M),
    .writec0_M (writec0_M),
    .EXLClr_M  (EXLClr_M),
    .HWInt     (HWInt),
    .CP0Out    (CP0Out),
    .EPCOut    (EPCOut),
    .req       (req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Read a CP0 register through the mfc0 port.
  task automatic rd(input logic [4:0] num, output logic [31:0] val);
    A1 = num;
    #1;
    val = CP0Out;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    A2 = 5'd0; DIn = 32'h0; PC_M = 32'h0; BD_M = 1'b0; ExcCode_M = 5'd0;
    writec0_M = 1'b0; EXLClr_M = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    reset = 1'b1; A1 = 5'd0; HWInt = 6'h0;
    quiet();
    tick(); tick();
    reset = 1'b0;
    #1;
    rd(5'd12, v); check("rst_sr", v, 32'h0);
    rd(5'd13, v); check("rst_cause", v, 32'h0);
    rd(5'd14, v); check("rst_epc", v, 32'h0);
    rd(5'd15, v); check("prid", v, 32'h2022_0007);
    rd(5'd3, v);  check("unmapped", v, 32'h0);
    check("rst_req", {31'h0, req}, 32'h0);

    // Synchronous exception, not in a delay slot.
    ExcCode_M = 5'd4; PC_M = 32'h3008; #1;
    check("exc_req", {31'h0, req}, 32'h1);
    tick(); quiet(); #1;
    check("exc_epc", EPCOut, 32'h3008);
    rd(5'd13, v); check("exc_cause", v, 32'h10);
    rd(5'd12, v); check("exc_sr", v, 32'h2);
    check("exc_req_off", {31'h0, req}, 32'h0);

    EXLClr_M = 1'b1; tick(); quiet();
    rd(5'd12, v); check("eret_sr", v, 32'h0);

    // Enable all interrupts, then interrupt beats a simultaneous exception.
    writec0_M = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01; tick(); quiet();
    rd(5'd12, v); check("mtc0_sr", v, 32'h0000_FC01);
    HWInt = 6'b000100; ExcCode_M = 5'd8; PC_M = 32'h3004; #1;
    check("int_req", {31'h0, req}, 32'h1);
    tick(); quiet();
    rd(5'd13, v); check("int_cause", v, 32'h0000_1000);
    check("int_epc", EPCOut, 32'h3004);
    rd(5'd12, v); check("int_sr", v, 32'h0000_FC03);

    // No nesting while EXL; eret wins over a same-cycle mtc0 setting EXL.
    ExcCode_M = 5'd4; #1;
    check("exl_mask", {31'h0, req}, 32'h0);
    ExcCode_M = 5'd0; EXLClr_M = 1'b1; writec0_M = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC03;
    tick(); quiet();
    rd(5'd12, v); check("eret_prio", v, 32'h0000_FC01);
    check("int_after_eret", {31'h0, req}, 32'h1);
    HWInt = 6'h0; #1;
    check("int_drop", {31'h0, req}, 32'h0);

    // Delay-slot exception with a suppressed mtc0 EPC write.
    ExcCode_M = 5'd10; BD_M = 1'b1; PC_M = 32'h3010;
    writec0_M = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEEF;
    tick(); quiet();
    check("bd_epc", EPCOut, 32'h300C);
    rd(5'd13, v); check("bd_cause", v, 32'h8000_0028);

    // PC 0 in a delay slot wraps.
    EXLClr_M = 1'b1; tick(); quiet();
    ExcCode_M = 5'd1; BD_M = 1'b1; PC_M = 32'h0; tick(); quiet();
    check("wrap_epc", EPCOut, 32'hFFFF_FFFC);
    rd(5'd13, v); check("wrap_cause", v, 32'h8000_0004);
    EXLClr_M = 1'b1; tick(); quiet();

    // mtc0 EPC appears only after the edge; Cause writes are ignored.
    writec0_M = 1'b1; A2 = 5'd14; DIn = 32'h1234_5677; #1;
    check("epc_pre", EPCOut, 32'hFFFF_FFFC);
    tick();
    A2 = 5'd13; DIn = 32'hFFFF_FFFF; tick(); quiet();
    check("epc_post", EPCOut, 32'h1234_5674);
    rd(5'd13, v); check("cause_ro", v, 32'h8000_0004);

    // Reset overrides a pending interrupt request and writes.
    HWInt = 6'b000001; #1;
    check("pre_rst_req", {31'h0, req}, 32'h1);
    reset = 1'b1; writec0_M = 1'b1; A2 = 5'd14; DIn = 32'h5555_5554; EXLClr_M = 1'b1;
    tick();
    reset = 1'b0; HWInt = 6'h0; quiet(); #1;
    rd(5'd12, v); check("rst2_sr", v, 32'h0);
    rd(5'd13, v); check("rst2_cause", v, 32'h0);
    check("rst2_epc", EPCOut, 32'h0);
    rd(5'd15, v); check("rst2_prid", v, 32'h2022_0007);
    check("rst2_req", {31'h0, req}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on posedge clk.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 A1  input  5  mfc0 read register number (M stage).
REQ-004 A2  input  5  mtc0 write register number (M stage).
REQ-005 DIn  input  32  mtc0 write data.
REQ-006 PC_M  input  32  PC of the instruction currently in M.
REQ-007 BD_M  input  1  M instruction sits in a branch delay slot.
REQ-008 ExcCode_M  input  5  exception code carried from E/M pipeline register; 0 = none.
REQ-009 writec0_M  input  1  mtc0 write enable.
REQ-010 EXLClr_M  input  1  eret in M; clears SR.EXL.
REQ-011 HWInt  input  6  external interrupt lines, level sensitive.
REQ-012 CP0Out  output  32  mfc0 read data, combinational on A1.
REQ-013 EPCOut  output  32  current EPC register value.
REQ-014 req  output  1  exception/interrupt request; drives pipeline-register flush inputs and PC redirect to 32'h0000_4180.

Function
REQ-015 Registers: SR (12) holds IM[15:10], EXL[1], IE[0], other bits read 0; Cause (13) holds BD[31], IP[15:10], ExcCode[6:2], other bits read 0; EPC (14) 32 bits; PRId (15) constant 32'h2022_0007.
REQ-016 CP0Out = addressed register per REQ-015; any other A1 returns 32'h0.
REQ-017 IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL, combinational.
REQ-018 ExcReq = (ExcCode_M != 0) & ~SR.EXL, combinational.
REQ-019 req = IntReq | ExcReq, combinational, same cycle as inputs; no registered latency.
REQ-020 Cause.IP is loaded from HWInt every cycle when not in reset, independent of req.
REQ-021 On a posedge with req=1: SR.EXL <= 1; Cause.BD <= BD_M; Cause.ExcCode <= IntReq ? 0 : ExcCode_M; EPC <= BD_M ? (PC_M - 4) : PC_M, with bits [1:0] forced to 0.
REQ-022 Interrupt has priority over a simultaneous synchronous exception; ExcCode recorded 0.
REQ-023 On a posedge with req=0 and writec0_M=1: A2=12 writes SR fields from DIn[15:10], DIn[1], DIn[0]; A2=14 writes EPC <= {DIn[31:2],2'b00}; writes to Cause, PRId, or other numbers are ignored.
REQ-024 On a posedge with req=0 and EXLClr_M=1: SR.EXL <= 0; this takes priority over a same-cycle mtc0 write of SR.EXL.
REQ-025 req=1 suppresses any same-cycle mtc0 write and EXLClr_M.
REQ-026 While SR.EXL=1, req stays 0 for any HWInt or ExcCode_M; no nesting.
REQ-027 PC_M - 4 wraps modulo 2^32 (PC_M=0 gives EPC 32'hFFFF_FFFC).
REQ-028 EPCOut reflects the register only; an EPC write becomes visible on EPCOut the cycle after the edge.

Reset
REQ-029 On reset: SR, Cause, and EPC clear to 0; PRId is unaffected; req evaluates to 0 because SR.IE=0 and ExcCode_M is expected 0 from the flushed pipeline.
REQ-030 Reset overrides req, writec0_M, and EXLClr_M in the same cycle.

Verification
REQ-031 Reset, then ExcCode_M=5'd4, BD_M=0, PC_M=32'h3008 -> req=1 same cycle; next cycle EPC=32'h3008, Cause[6:2]=4, SR.EXL=1, req=0.
REQ-032 mtc0 SR with DIn=32'h0000_FC01, then HWInt=6'b000100 -> req=1; after edge Cause[6:2]=0, Cause[12]=1.
REQ-033 ExcCode_M=5'd10, BD_M=1, PC_M=32'h3010 -> EPC=32'h300C, Cause[31]=1.
REQ-034 EXL=1 with HWInt enabled and ExcCode_M=4 -> req=0; then EXLClr_M=1 -> EXL=0 and req rises the following cycle.
REQ-035 req=1 with writec0_M=1, A2=14, DIn=32'hDEAD_BEEF -> EPC holds the exception PC, not DIn.
REQ-036 reset asserted together with req=1 -> all registers are 0 next cycle.
